// File: rtl/lc3b_types_pkg.sv
// Shared lc3b datapath types: words, fetch-buffer entries and fetch FSM states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word instr;
  } lc3b_fetch_entry;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DRAIN
  } fetch_state_t;

  localparam lc3b_word LC3B_INSTR_BYTES = 16'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs; flush empties it.
module fetch_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  lc3b_fetch_entry         push_data,
  input  logic                    pop,
  output lc3b_fetch_entry         head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  lc3b_fetch_entry mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// lc3b instruction fetch: owns the fetch PC, issues single outstanding reads,
// buffers responses and presents them to the IR with valid/ready.
module fetch_unit
  import lc3b_types::*;
#(
  parameter int       DEPTH    = 2,
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  output lc3b_word mem_address,
  output logic     mem_read,
  input  logic     mem_resp,
  input  lc3b_word mem_rdata,
  output logic     instr_valid,
  input  logic     instr_ready,
  output lc3b_word instr,
  output lc3b_word instr_pc,
  output lc3b_word instr_next_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  fetch_state_t    state_q, state_d;
  lc3b_word        fetch_pc_q, fetch_pc_d;
  lc3b_word        mem_addr_q, mem_addr_d;
  logic            resp_accept;
  lc3b_fetch_entry head;
  logic [CNT_W-1:0] fifo_count;
  logic            fifo_empty, fifo_full;

  // State, fetch PC and the request address (frozen while a read is out).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next state: a redirect turns an in-flight read into a drain so its
  // response is swallowed rather than aborted at the memory.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_accept = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        if (!redirect && (fifo_count < CNT_DEPTH)) state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (mem_resp) begin
          state_d = FETCH_IDLE;
          if (!redirect) begin
            resp_accept = 1'b1;
            fetch_pc_d  = fetch_pc_q + LC3B_INSTR_BYTES;
          end
        end else if (redirect) begin
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (mem_resp) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (redirect) fetch_pc_d = {redirect_pc[15:1], 1'b0};
    mem_addr_d = ((state_q == FETCH_IDLE) || (state_d == FETCH_IDLE)) ? fetch_pc_d : mem_addr_q;
  end

  // Outputs: the read is held for the whole of REQ and DRAIN.
  always_comb begin
    mem_read    = (state_q != FETCH_IDLE);
    mem_address = mem_addr_q;
    instr_valid = ~fifo_empty & ~redirect;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (resp_accept & ~fifo_full),
    .push_data ('{pc: fetch_pc_q, instr: mem_rdata}),
    .pop       (instr_valid & instr_ready),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign instr         = head.instr;
  assign instr_pc      = head.pc;
  assign instr_next_pc = head.pc + LC3B_INSTR_BYTES;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: 3-cycle latency memory, queue-based reference model,
// and directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam int       DEPTH    = 2;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr, instr_pc, instr_next_pc;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_address(mem_address), .mem_read(mem_read), .mem_resp(mem_resp),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_next_pc(instr_next_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a * 16'd3 + 16'h1234;
  endfunction

  // ---------------- memory model: 3-cycle latency, cannot abort -------------
  logic [15:0] issued[$];
  logic        pend = 1'b0;
  logic [15:0] paddr;
  int          cnt;
  logic        late_resp = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #2;
      mem_resp  = 1'b0;
      mem_rdata = 16'hDEAD;
      if (pend) begin
        if (mem_read) chk("addr_stable", mem_address, paddr);
        if (cnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = mdata(paddr);
          pend      = 1'b0;
          if (reset) late_resp = 1'b1;
        end else cnt--;
      end else if (mem_read && !reset) begin
        pend  = 1'b1;
        paddr = mem_address;
        cnt   = 1;
        issued.push_back(mem_address);
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {logic [15:0] pc; logic [15:0] ins;} ent_t;
  ent_t        mq[$];
  logic        m_busy = 1'b0, m_discard = 1'b0;
  logic [15:0] m_pc = RST_PC, m_req = RST_PC;
  logic        model_on = 1'b0;

  initial begin
    logic start, dpop, got;
    wait (model_on);
    forever begin
      @(negedge clk); #3;
      chk("mem_read", {15'd0, mem_read}, {15'd0, m_busy});
      chk("mem_address", mem_address, m_busy ? m_req : m_pc);
      chk("instr_valid", {15'd0, instr_valid}, {15'd0, (mq.size() != 0) && !redirect});
      if ((mq.size() != 0) && !redirect) begin
        chk("instr", instr, mq[0].ins);
        chk("instr_pc", instr_pc, mq[0].pc);
        chk("instr_next_pc", instr_next_pc, mq[0].pc + 16'd2);
      end
      if (reset) begin
        mq.delete(); m_busy = 0; m_discard = 0; m_pc = RST_PC;
      end else begin
        start = !m_busy && (mq.size() < DEPTH) && !redirect;
        dpop  = !redirect && (mq.size() != 0) && instr_ready;
        got   = m_busy && mem_resp;
        if (dpop) void'(mq.pop_front());
        if (got) begin
          if (!redirect && !m_discard) begin
            mq.push_back('{pc: m_req, ins: mem_rdata});
            m_pc = m_pc + 16'd2;
          end
          m_busy = 0; m_discard = 0;
        end else if (m_busy && redirect) m_discard = 1;
        if (redirect) begin
          mq.delete();
          m_pc = redirect_pc & 16'hFFFE;
        end
        if (start) begin m_busy = 1; m_req = m_pc; end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!instr_valid && n < max) begin @(negedge clk); #2; n++; end
    if (!instr_valid) begin
      checks++; errors++;
      $display("FAIL %s: timeout waiting for instr_valid", name);
    end
  endtask

  task automatic wait_issued(input string name, input int sz, input int max);
    int n = 0;
    while (issued.size() < sz && n < max) begin @(posedge clk); #1; n++; end
    if (issued.size() < sz) begin
      checks++; errors++;
      $display("FAIL %s: timeout, issued %0d expected %0d", name, issued.size(), sz);
    end
  endtask

  initial begin
    logic [15:0] pcs[$];
    logic [15:0] nps[$];
    logic [15:0] first_ins;
    int n;
    logic hit;

    repeat (3) @(posedge clk);
    #1 model_on = 1'b1;
    @(negedge clk); #2;
    chk("rst_mem_read", {15'd0, mem_read}, 16'd0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_addr", mem_address, 16'h0000);

    // first fetch
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #2;
    chk("first_no_read_yet", {15'd0, mem_read}, 16'd0);
    @(negedge clk); #2;
    chk("first_read", {15'd0, mem_read}, 16'd1);
    chk("first_addr", mem_address, 16'h0000);
    wait_valid("first_valid", 10);
    chk("first_instr", instr, 16'h1234);
    chk("first_pc", instr_pc, 16'h0000);
    chk("first_next_pc", instr_next_pc, 16'h0002);

    // FIFO fills with ready low
    repeat (20) @(posedge clk);
    #1;
    chk("fill_reads", 16'(issued.size()), 16'd2);
    chk("fill_addr1", issued[1], 16'h0002);
    chk("fill_idle", {15'd0, mem_read}, 16'd0);
    instr_ready = 1'b1;
    @(posedge clk); #1 instr_ready = 1'b0;
    @(negedge clk); #2;
    chk("pop_head_pc", instr_pc, 16'h0002);
    wait_issued("third_read", 3, 10);
    chk("third_addr", issued[2], 16'h0004);

    // redirect while 0004 outstanding
    redirect = 1'b1; redirect_pc = 16'h3001;
    @(negedge clk); #2;
    chk("redir_mask_valid", {15'd0, instr_valid}, 16'd0);
    @(posedge clk); #1 redirect = 1'b0;
    wait_issued("redir_read", 4, 12);
    chk("redir_addr", issued[3], 16'h3000);
    wait_valid("redir_valid", 12);
    chk("redir_head_pc", instr_pc, 16'h3000);
    chk("redir_head_instr", instr, 16'hA234);

    // redirect coinciding with mem_resp
    instr_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk); #1;
      if (mem_resp) begin
        hit = 1'b1;
        redirect = 1'b1; redirect_pc = 16'h4000;
      end
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL resp_redir: no mem_resp seen");
    end
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk); #2;
    chk("rr_idle", {15'd0, mem_read}, 16'd0);
    chk("rr_addr", mem_address, 16'h4000);
    chk("rr_no_stale", {15'd0, instr_valid}, 16'd0);
    @(negedge clk); #2;
    chk("rr_read", {15'd0, mem_read}, 16'd1);
    chk("rr_read_addr", mem_address, 16'h4000);

    // wrap around top of memory
    repeat (3) @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(posedge clk); #1 redirect = 1'b0;
    n = 0;
    first_ins = 16'h0000;
    while (pcs.size() < 3 && n < 80) begin
      @(negedge clk); #2; n++;
      if (instr_valid && instr_ready) begin
        if (pcs.size() == 0) first_ins = instr;
        pcs.push_back(instr_pc);
        nps.push_back(instr_next_pc);
      end
    end
    if (pcs.size() < 3) begin
      checks++; errors++;
      $display("FAIL wrap: only %0d pops seen", pcs.size());
    end else begin
      chk("wrap_pc0", pcs[0], 16'hFFFE);
      chk("wrap_pc1", pcs[1], 16'h0000);
      chk("wrap_pc2", pcs[2], 16'h0002);
      chk("wrap_next0", nps[0], 16'h0000);
      chk("wrap_instr0", first_ins, 16'h122E);
    end

    // reset while a read is outstanding
    n = issued.size();
    wait_issued("pre_reset_read", n + 1, 12);
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #2;
    chk("midrst_read", {15'd0, mem_read}, 16'd0);
    chk("midrst_valid", {15'd0, instr_valid}, 16'd0);
    chk("midrst_addr", mem_address, RST_PC);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("late_resp_seen", {15'd0, late_resp}, 16'd1);
    wait_valid("post_rst_valid", 12);
    chk("post_rst_pc", instr_pc, 16'h0000);
    chk("post_rst_instr", instr, 16'h1234);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
